// File: rtl/pulse_train_if.sv
// Control and status bundle of the pulse train generator.
// The master (controller or bench) drives the train request; the slave generates it.
interface pulse_train_if #(
    parameter int unsigned CNT_BITS   = 8,
    parameter int unsigned PULSE_BITS = 4
);
    logic                  start;
    logic                  abort;
    logic [CNT_BITS-1:0]   high_len;
    logic [CNT_BITS-1:0]   low_len;
    logic [PULSE_BITS-1:0] num_pulses;
    logic                  pulse_out;
    logic                  busy;
    logic                  done;
    logic [PULSE_BITS-1:0] pulses_sent;

    modport master (
        output start, abort, high_len, low_len, num_pulses,
        input  pulse_out, busy, done, pulses_sent
    );

    modport slave (
        input  start, abort, high_len, low_len, num_pulses,
        output pulse_out, busy, done, pulses_sent
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Programmable level pulse train: num_pulses pulses of high_len clocks separated by
// max(low_len,1) clocks low, with a one-cycle done strobe; all outputs registered.
module pulse_train_generator #(
    parameter int unsigned CNT_BITS   = 8,
    parameter int unsigned PULSE_BITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    pulse_train_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   phase_q, phase_d;
    logic [CNT_BITS-1:0]   high_len_q, high_len_d;
    logic [CNT_BITS-1:0]   low_len_q, low_len_d;
    logic [PULSE_BITS-1:0] num_q, num_d;
    logic [PULSE_BITS-1:0] sent_q, sent_d;
    logic                  pulse_q, pulse_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  phase_end;
    logic                  more_pulses;
    logic [PULSE_BITS-1:0] sent_inc;
    logic [CNT_BITS-1:0]   low_load;

    assign accept    = (state_q == StIdle) && bus.start && !bus.abort;
    assign phase_end = (phase_q == '0);
    // sent_q < num_q whenever HIGH runs, so the increment cannot wrap
    assign sent_inc    = sent_q + 1'b1;
    assign more_pulses = (sent_inc < num_q);
    // A zero low phase is stretched to one cycle so adjacent pulses stay separate
    assign low_load  = (low_len_q == '0) ? '0 : low_len_q - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            high_len_q <= '0;
            low_len_q  <= '0;
            num_q      <= '0;
            sent_q     <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            num_q      <= num_d;
            sent_q     <= sent_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        num_d      = num_q;
        sent_d     = sent_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    high_len_d = bus.high_len;
                    low_len_d  = bus.low_len;
                    num_d      = bus.num_pulses;
                    sent_d     = '0;
                    if (bus.high_len == '0 || bus.num_pulses == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StHigh;
                        phase_d = bus.high_len - 1'b1;
                    end
                end
            end
            StHigh: begin
                if (phase_end) begin
                    sent_d = sent_inc;
                    if (more_pulses) begin
                        state_d = StLow;
                        phase_d = low_load;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            StLow: begin
                if (phase_end) begin
                    state_d = StHigh;
                    phase_d = high_len_q - 1'b1;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition and freezes the pulse count
        if (bus.abort && state_q != StIdle) begin
            state_d = StIdle;
            phase_d = '0;
            sent_d  = sent_q;
        end
    end

    always_comb begin
        pulse_d = (state_d == StHigh);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_sent = sent_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: an arithmetic train model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_pulse_train_generator;
    typedef struct packed {
        logic       pulse;
        logic       busy;
        logic       done;
        logic [3:0] sent;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    bit   chk_en;

    bit       m_active;
    int       m_t0;
    int       m_h;
    int       m_l;
    int       m_n;
    logic [3:0] m_sent;

    pulse_train_if #(.CNT_BITS(8), .PULSE_BITS(4)) bus ();

    pulse_train_generator #(.CNT_BITS(8), .PULSE_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Expected outputs at cycle c from the train parameters alone
    function automatic exp_t model_out(input int c);
        exp_t e;
        int r, per, tlen, off;
        e = '0;
        e.sent = m_sent;
        if (m_active) begin
            r = c - m_t0;
            e.sent = '0;
            if (m_h == 0 || m_n == 0) begin
                if (r == 1) begin
                    e.busy = 1'b1;
                    e.done = 1'b1;
                end
            end else begin
                per  = m_h + m_l;
                tlen = m_n * m_h + (m_n - 1) * m_l;
                if (r <= tlen) begin
                    off     = (r - 1) % per;
                    e.busy  = 1'b1;
                    e.pulse = (off < m_h);
                    e.sent  = 4'((r - 1) / per + ((off >= m_h) ? 1 : 0));
                end else begin
                    e.sent = 4'(m_n);
                    if (r == tlen + 1) begin
                        e.busy = 1'b1;
                        e.done = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    function automatic logic model_busy(input int c);
        exp_t e;
        e = model_out(c);
        return e.busy;
    endfunction

    function automatic logic [3:0] model_sent(input int c);
        exp_t e;
        e = model_out(c);
        return e.sent;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_sent   <= '0;
            m_t0     <= 0;
        end else if (model_busy(cyc)) begin
            if (bus.abort) begin
                m_active <= 1'b0;
                m_sent   <= model_sent(cyc);
            end
        end else if (bus.start && !bus.abort) begin
            m_active <= 1'b1;
            m_t0     <= cyc;
            m_h      <= int'(bus.high_len);
            m_l      <= (bus.low_len == 8'd0) ? 1 : int'(bus.low_len);
            m_n      <= int'(bus.num_pulses);
        end
    end

    task automatic compare_cycle();
        exp_t e;
        exp_t g;
        e = model_out(cyc);
        g = {bus.pulse_out, bus.busy, bus.done, bus.pulses_sent};
        check($sformatf("cycle %0d {pulse,busy,done,sent}", cyc), int'(g), int'(e));
    endtask

    always @(negedge clk) if (chk_en) compare_cycle();

    task automatic launch(input int h, input int l, input int n);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.high_len   = 8'(h);
        bus.low_len    = 8'(l);
        bus.num_pulses = 4'(n);
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    initial begin
        logic [11:0] pat_p, pat_b, pat_d;
        int run, runs, dones;

        total = 0;
        bad   = 0;
        cyc   = 0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.high_len   = '0;
        bus.low_len    = '0;
        bus.num_pulses = '0;
        reset  = 1'b1;
        chk_en = 1'b0;
        #1 chk_en = 1'b1;
        idle(3);
        check("reset busy", int'(bus.busy), 0);
        check("reset sent", int'(bus.pulses_sent), 0);
        reset = 1'b0;
        idle(2);

        // 1: two pulses of 3 high, 2 low
        launch(3, 2, 2);
        for (int i = 0; i < 12; i++) begin
            pat_p[i] = bus.pulse_out;
            pat_b[i] = bus.busy;
            pat_d[i] = bus.done;
            @(negedge clk);
        end
        check("t1 pulse pattern", int'(pat_p), 'h0E7);
        check("t1 busy pattern", int'(pat_b), 'h1FF);
        check("t1 done pattern", int'(pat_d), 'h100);
        check("t1 pulses_sent", int'(bus.pulses_sent), 2);

        // 2: zero high_len, then zero num_pulses
        launch(0, 5, 4);
        check("t2a done", int'(bus.done), 1);
        check("t2a pulse", int'(bus.pulse_out), 0);
        @(negedge clk);
        check("t2a busy after", int'(bus.busy), 0);
        check("t2a sent", int'(bus.pulses_sent), 0);
        launch(3, 1, 0);
        check("t2b done", int'(bus.done), 1);
        @(negedge clk);
        check("t2b sent", int'(bus.pulses_sent), 0);
        idle(2);

        // 3: single-cycle pulses with low_len 0
        launch(1, 0, 3);
        for (int i = 0; i < 6; i++) begin
            pat_p[i] = bus.pulse_out;
            pat_d[i] = bus.done;
            @(negedge clk);
        end
        check("t3 pulse pattern", int'(pat_p[5:0]), 'b010101);
        check("t3 done pattern", int'(pat_d[5:0]), 'b100000);
        idle(2);

        // 4: start while busy ignored, abort, restart
        launch(5, 2, 1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("t4 abort pulse", int'(bus.pulse_out), 0);
        check("t4 abort busy", int'(bus.busy), 0);
        check("t4 abort done", int'(bus.done), 0);
        bus.abort = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4 restart pulse", int'(bus.pulse_out), 1);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 1);
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("t4 done count", dones, 1);
        check("t4 sent", int'(bus.pulses_sent), 1);

        // 5: async reset in the middle of a low phase
        launch(4, 4, 3);
        idle(5);
        check("t5 in low", int'(bus.pulse_out), 0);
        #2 reset = 1'b1;
        #1;
        check("t5 async busy", int'(bus.busy), 0);
        check("t5 async sent", int'(bus.pulses_sent), 0);
        idle(2);
        reset = 1'b0;
        idle(6);
        check("t5 stays idle", int'(bus.busy), 0);

        // 6: maximum high_len and pulse count
        launch(255, 1, 15);
        run   = 0;
        runs  = 0;
        dones = 0;
        for (int i = 0; i < 4000; i++) begin
            if (bus.pulse_out) begin
                run++;
            end else if (run > 0) begin
                check($sformatf("t6 high run %0d", runs), run, 255);
                runs++;
                run = 0;
            end
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("t6 run count", runs, 15);
        check("t6 done count", dones, 1);
        check("t6 sent", int'(bus.pulses_sent), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
